// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, memory op codes and MEM stage states
package mem_stage_pkg;
  localparam int RegLen = 32;
  localparam int RegAddrLen = 5;
  localparam int MemOpLen = 4;
  localparam logic ResetEnable = 1'b1;

  typedef enum logic [MemOpLen-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Undefined codes report zero bytes so they behave exactly like NONE.
  function automatic logic [2:0] op_bytes(input logic [MemOpLen-1:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_bytes = 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: op_bytes = 3'd2;
      MEM_LW, MEM_SW:          op_bytes = 3'd4;
      default:                 op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [MemOpLen-1:0] op);
    op_is_load = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
                 (op == MEM_LBU) || (op == MEM_LHU);
  endfunction
endpackage

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - little-endian load buffer to sign/zero-extended word
module mem_load_ext
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = RegLen
) (
  input  logic [31:0]         byte_buf_i,
  input  logic [MemOpLen-1:0] op_i,
  output logic [DATA_W-1:0]   data_o
);
  always_comb begin
    data_o = '0;
    case (op_i)
      MEM_LB:  data_o = DATA_W'($signed(byte_buf_i[7:0]));
      MEM_LH:  data_o = DATA_W'($signed(byte_buf_i[15:0]));
      MEM_LBU: data_o = DATA_W'(byte_buf_i[7:0]);
      MEM_LHU: data_o = DATA_W'(byte_buf_i[15:0]);
      MEM_LW:  data_o = DATA_W'(byte_buf_i);
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage driving a byte-wide memory-controller port
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = RegLen,
  parameter int REG_ADDR_W = RegAddrLen,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     mem_rd_data,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_rd_enable,
  input  logic [MemOpLen-1:0]   mem_op,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_store_data,
  output logic [DATA_W-1:0]     wb_rd_data,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic                  wb_rd_enable,
  output logic                  stall_req,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [ADDR_W-1:0]     mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic                  mc_grant,
  input  logic                  mc_rvalid,
  input  logic [7:0]            mc_rdata
);
  state_e                state_q, state_d;
  logic [MemOpLen-1:0]   op_q, op_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [31:0]           sdata_q, sdata_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [2:0]            issue_cnt_q, issue_cnt_d;
  logic [2:0]            recv_cnt_q, recv_cnt_d;
  logic [31:0]           byte_buf_q, byte_buf_d;
  logic [DATA_W-1:0]     load_data;
  logic [2:0]            nbytes;
  logic [2:0]            in_bytes;
  logic                  is_load;

  assign nbytes   = op_bytes(op_q);
  assign in_bytes = op_bytes(mem_op);
  assign is_load  = op_is_load(op_q);

  mem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .byte_buf_i(byte_buf_q),
    .op_i      (op_q),
    .data_o    (load_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    sdata_d     = sdata_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = rd_en_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    byte_buf_d  = byte_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_bytes != 3'd0) begin
          state_d     = ST_XFER;
          op_d        = mem_op;
          base_d      = mem_addr;
          sdata_d     = mem_store_data[31:0];
          rd_addr_d   = mem_rd_addr;
          rd_en_d     = mem_rd_enable;
          issue_cnt_d = 3'd0;
          recv_cnt_d  = 3'd0;
        end
      end
      ST_XFER: begin
        if (mc_grant) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_d == nbytes) state_d = is_load ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (mc_rvalid && (recv_cnt_q + 3'd1 == nbytes)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Read bytes can land while later bytes are still being issued.
    if ((state_q == ST_XFER || state_q == ST_WAIT) && mc_rvalid) begin
      byte_buf_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mc_rdata;
      recv_cnt_d = recv_cnt_q + 3'd1;
    end
  end

  always_comb begin
    wb_rd_data   = '0;
    wb_rd_addr   = '0;
    wb_rd_enable = 1'b0;
    stall_req    = 1'b0;
    mc_req       = 1'b0;
    mc_we        = 1'b0;
    mc_addr      = '0;
    mc_wdata     = '0;
    if (rst != ResetEnable) begin
      case (state_q)
        ST_IDLE: begin
          if (in_bytes == 3'd0) begin
            wb_rd_data   = mem_rd_data;
            wb_rd_addr   = mem_rd_addr;
            wb_rd_enable = mem_rd_enable;
          end else begin
            stall_req = 1'b1;
          end
        end
        ST_XFER: begin
          stall_req = 1'b1;
          mc_req    = 1'b1;
          mc_we     = !is_load;
          mc_addr   = base_q + ADDR_W'(issue_cnt_q);
          if (!is_load) mc_wdata = sdata_q[{issue_cnt_q[1:0], 3'b000} +: 8];
        end
        ST_WAIT: stall_req = 1'b1;
        ST_DONE: begin
          wb_rd_addr   = rd_addr_q;
          wb_rd_enable = rd_en_q && is_load;
          if (is_load) wb_rd_data = load_data;
        end
        default: stall_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      base_q      <= '0;
      sdata_q     <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      byte_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      sdata_q     <= sdata_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      byte_buf_q  <= byte_buf_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a byte-memory controller model
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_rd_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_enable;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] wb_rd_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_enable;
  logic        stall_req;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic        mc_grant;
  logic        mc_rvalid;
  logic [7:0]  mc_rdata;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
    .stall_req(stall_req), .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_grant(mc_grant), .mc_rvalid(mc_rvalid), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        is_store;
  } wb_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } mc_t;

  int          checks = 0;
  int          errors = 0;
  wb_t         wb_q[$];
  mc_t         mc_q[$];
  wb_t         mon_w;
  mc_t         mon_m;
  logic [7:0]  ref_mem[int unsigned];
  logic [7:0]  bus_mem[int unsigned];
  logic        active = 1'b0;
  logic        rand_grant = 1'b0;
  int          grant_block = 0;
  int          grants_seen = 0;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_addr_p = '0;
  logic        stray = 1'b0;
  logic [31:0] last_wb_data = '0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[23:16] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ref_mem[a] = b;
    bus_mem[a] = b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference: an instruction is a byte count, a direction and an extension rule over a byte memory.
  task automatic model(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdd, input logic [4:0] rda, input logic rde);
    int n;
    bit ld, sgn;
    logic [31:0] v, a;
    wb_t w;
    mc_t m;
    n = 0; ld = 0; sgn = 0;
    case (op)
      1: begin n = 1; ld = 1; sgn = 1; end
      2: begin n = 2; ld = 1; sgn = 1; end
      3: begin n = 4; ld = 1; end
      4: begin n = 1; ld = 1; end
      5: begin n = 2; ld = 1; end
      6: n = 1;
      7: n = 2;
      8: n = 4;
      default: n = 0;
    endcase
    w.en = rde; w.addr = rda; w.data = rdd; w.is_store = 1'b0;
    if (n > 0 && ld) begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        a = addr + i;
        v = v | (32'(ref_rd(a)) << (8 * i));
        m.we = 1'b0; m.addr = a; m.wdata = 8'h00;
        mc_q.push_back(m);
      end
      if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      w.data = v;
    end else if (n > 0) begin
      for (int i = 0; i < n; i++) begin
        a = addr + i;
        m.we = 1'b1; m.addr = a; m.wdata = 8'(sdata >> (8 * i));
        ref_mem[a] = m.wdata;
        mc_q.push_back(m);
      end
      w.en = 1'b0;
      w.is_store = 1'b1;
    end
    wb_q.push_back(w);
  endtask

  task automatic drive(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdd, input logic [4:0] rda, input logic rde);
    mem_op = 4'(op); mem_addr = addr; mem_store_data = sdata;
    mem_rd_data = rdd; mem_rd_addr = rda; mem_rd_enable = rde;
  endtask

  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdd, input logic [4:0] rda, input logic rde,
                       output int stall_cycles);
    @(posedge clk); #1;
    model(op, addr, sdata, rdd, rda, rde);
    drive(op, addr, sdata, rdd, rda, rde);
    active = 1'b1;
    stall_cycles = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!stall_req) break;
      stall_cycles++;
    end
    if (stall_req) begin
      checks++; errors++;
      $display("FAIL retire_timeout: actual stall_req=1 after 300 cycles required retire, op %0d", op);
    end
    #1;
  endtask

  // Monitor: retirement is any non-stalled cycle; bus requests are checked every cycle they are raised.
  always @(negedge clk) begin
    if (!rst && active && !stall_req) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: actual retire required none");
      end else begin
        mon_w = wb_q.pop_front();
        check("wb_en", wb_rd_enable, mon_w.en);
        check("wb_addr", wb_rd_addr, mon_w.addr);
        if (!mon_w.is_store) check("wb_data", wb_rd_data, mon_w.data);
        last_wb_data = wb_rd_data;
      end
    end
    if (!rst && mc_req) begin
      if (mc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mc_unexpected: actual req at %h required none", mc_addr);
      end else begin
        check("mc_addr", mc_addr, mc_q[0].addr);
        if (mc_grant) begin
          mon_m = mc_q.pop_front();
          check("mc_we", mc_we, mon_m.we);
          grants_seen++;
          if (mc_we) begin
            check("mc_wdata", mc_wdata, mon_m.wdata);
            bus_mem[mc_addr] = mc_wdata;
          end else begin
            rd_pending = 1'b1;
            rd_addr_p  = mc_addr;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mc_rvalid  = rd_pending | stray;
    mc_rdata   = rd_pending ? bus_rd(rd_addr_p) : 8'hEE;
    rd_pending = 1'b0;
    stray      = 1'b0;
    #1;
    if (mc_req && grant_block > 0) begin
      mc_grant = 1'b0;
      grant_block--;
    end else begin
      mc_grant = rand_grant ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    int sc;
    int g0;
    rst = 1'b1;
    mc_grant = 1'b0; mc_rvalid = 1'b0; mc_rdata = 8'h00;
    drive(3, 32'h100, 32'h5555_AAAA, 32'hDEAD_BEEF, 5'd9, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_data", wb_rd_data, 32'h0);
    check("rst_ctrl", {stall_req, mc_req, mc_we, wb_rd_enable, wb_rd_addr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 1'b0);
    @(negedge clk);
    check("post_rst_outs", {wb_rd_data[7:0], stall_req, mc_req, mc_we, wb_rd_enable, wb_rd_addr, mc_wdata}, 32'h0);

    issue(0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, sc);
    check("pass_latency", sc, 0);
    check("pass_data", last_wb_data, 32'h1234_5678);

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    issue(3, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, sc);
    check("lw_latency", sc, 6);
    check("lw_data", last_wb_data, 32'h1234_5678);

    poke(32'h40, 8'h80);
    issue(1, 32'h40, 32'h0, 32'h0, 5'd3, 1'b1, sc);
    check("lb_latency", sc, 3);
    check("lb_data", last_wb_data, 32'hFFFF_FF80);
    issue(4, 32'h40, 32'h0, 32'h0, 5'd3, 1'b1, sc);
    check("lbu_data", last_wb_data, 32'h0000_0080);

    poke(32'h50, 8'h34); poke(32'h51, 8'hF2);
    issue(2, 32'h50, 32'h0, 32'h0, 5'd4, 1'b1, sc);
    check("lh_latency", sc, 4);
    check("lh_data", last_wb_data, 32'hFFFF_F234);

    grant_block = 2;
    issue(7, 32'h20, 32'hAABB_CCDD, 32'h0, 5'd6, 1'b1, sc);
    check("sh_latency", sc, 5);
    check("sh_byte0", bus_rd(32'h20), 32'hDD);
    check("sh_byte1", bus_rd(32'h21), 32'hCC);

    issue(3, 32'hFFFF_FFFE, 32'h0, 32'h0, 5'd8, 1'b1, sc);
    check("lw_wrap_latency", sc, 6);

    // Reset lands after the second granted byte of a word load.
    active = 1'b0;
    @(posedge clk); #1;
    model(3, 32'h200, 32'h0, 32'h0, 5'd10, 1'b1);
    drive(3, 32'h200, 32'h0, 32'h0, 5'd10, 1'b1);
    g0 = grants_seen;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (grants_seen - g0 >= 2) break;
    end
    check("rst_mid_grants", grants_seen - g0, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {wb_rd_data[7:0], stall_req, mc_req, mc_we, wb_rd_enable, wb_rd_addr}, 32'h0);
    stray = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wb_q.delete();
    mc_q.delete();
    drive(0, 0, 0, 0, 5'd0, 1'b0);
    @(negedge clk);
    check("after_rst_outs", {wb_rd_data[7:0], stall_req, mc_req, mc_we, wb_rd_enable, wb_rd_addr, mc_wdata}, 32'h0);
    issue(1, 32'h40, 32'h0, 32'h0, 5'd11, 1'b1, sc);
    check("lb_after_rst_latency", sc, 3);
    check("lb_after_rst_data", last_wb_data, 32'hFFFF_FF80);

    rand_grant = 1'b1;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                      : 32'($urandom_range(0, 63));
      issue($urandom_range(0, 15), a, $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), sc);
    end
    active = 1'b0;
    check("wb_queue_drained", wb_q.size(), 0);
    check("mc_queue_drained", mc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
